// File: rtl/alu_mdu_if.sv
// Request/result bundle between the execute stage and the ALU/MDU.
// Latency: n/a (wires only).
// Backpressure: the master may only have start accepted while ready=1.
interface alu_mdu_if #(
   parameter int WIDTH = 32
);
   localparam int SHW = $clog2(WIDTH);

   logic             start;
   logic [4:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [SHW-1:0]   shamt;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             zero;
   logic             div_by_zero;

   modport master (
      output start, op, a, b, shamt,
      input  ready, done, hi, lo, zero, div_by_zero
   );

   modport slave (
      input  start, op, a, b, shamt,
      output ready, done, hi, lo, zero, div_by_zero
   );
endinterface

// File: rtl/alu_mdu.sv
// Sequential ALU with registered HI/LO plus iterative shift-add multiply / restoring divide.
// Latency: single-cycle ops done 1 cycle after accept; mult/div done WIDTH+2 cycles after accept.
// Backpressure: ready=0 while a mult/div is in flight; start is ignored (not queued) when ready=0.
module alu_mdu #(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic       clk,
   input  logic       reset,
   alu_mdu_if.slave   bus
);

   localparam logic [4:0] OP_AND  = 5'b00000;
   localparam logic [4:0] OP_OR   = 5'b00001;
   localparam logic [4:0] OP_NOR  = 5'b00010;
   localparam logic [4:0] OP_XOR  = 5'b00011;
   localparam logic [4:0] OP_ADD  = 5'b00100;
   localparam logic [4:0] OP_SUB  = 5'b00101;
   localparam logic [4:0] OP_SLL  = 5'b01000;
   localparam logic [4:0] OP_SRL  = 5'b01001;
   localparam logic [4:0] OP_SRA0 = 5'b01010;
   localparam logic [4:0] OP_SRA1 = 5'b01011;
   localparam logic [4:0] OP_SLT  = 5'b01100;
   localparam logic [4:0] OP_SLTU = 5'b01101;

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

   state_t           state;
   logic [SHW-1:0]   cnt;
   // Shared iteration registers: for multiply p_hi:p_lo is the running
   // product with the multiplier shifting out of p_lo; for divide p_hi is
   // the partial remainder and p_lo the dividend/quotient shift register.
   logic [WIDTH-1:0] p_hi;
   logic [WIDTH-1:0] p_lo;
   logic [WIDTH-1:0] mcand;
   logic             neg_q;
   logic             neg_r;
   logic             is_div;
   logic             dbz_pend;

   logic             is_mul_op;
   logic             is_div_op;
   logic             sgn_op;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH-1:0] alu_res;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_rs;
   logic             div_ge;
   logic [WIDTH-1:0] div_r_nx;
   logic [WIDTH-1:0] div_q_nx;

   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   q_fix;
   logic [WIDTH-1:0]   r_fix;
   logic [WIDTH-1:0]   fix_hi;
   logic [WIDTH-1:0]   fix_lo;

   // Decode the request and form operand magnitudes for the iterative unit.
   always_comb begin
      is_mul_op = (bus.op[4:1] == 4'b0011);
      is_div_op = (bus.op[4:1] == 4'b1000);
      sgn_op    = ~bus.op[0];
      mag_a     = (sgn_op && bus.a[WIDTH-1]) ? (-bus.a) : bus.a;
      mag_b     = (sgn_op && bus.b[WIDTH-1]) ? (-bus.b) : bus.b;
   end

   // Single-cycle result; unlisted codes yield zero.
   always_comb begin
      alu_res = '0;
      case (bus.op)
         OP_AND:           alu_res = bus.a & bus.b;
         OP_OR:            alu_res = bus.a | bus.b;
         OP_NOR:           alu_res = ~(bus.a | bus.b);
         OP_XOR:           alu_res = bus.a ^ bus.b;
         OP_ADD:           alu_res = bus.a + bus.b;
         OP_SUB:           alu_res = bus.a - bus.b;
         OP_SLL:           alu_res = bus.b << bus.shamt;
         OP_SRL:           alu_res = bus.b >> bus.shamt;
         OP_SRA0, OP_SRA1: alu_res = $signed(bus.b) >>> bus.shamt;
         OP_SLT:           alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
         OP_SLTU:          alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
         default:          alu_res = '0;
      endcase
   end

   // One iteration step of shift-add multiply and restoring divide.
   always_comb begin
      mul_sum  = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
      div_rs   = {p_hi, p_lo[WIDTH-1]};
      div_ge   = (div_rs >= {1'b0, mcand});
      // When div_ge the true difference is below mcand, so W-bit modular math is exact.
      div_r_nx = div_ge ? (div_rs[WIDTH-1:0] - mcand) : div_rs[WIDTH-1:0];
      div_q_nx = {p_lo[WIDTH-2:0], div_ge};
   end

   // Sign correction applied in FIX; divide-by-zero forces an all-ones quotient.
   always_comb begin
      prod     = {p_hi, p_lo};
      prod_fix = neg_q ? (-prod) : prod;
      q_fix    = dbz_pend ? '1 : (neg_q ? (-p_lo) : p_lo);
      r_fix    = neg_r ? (-p_hi) : p_hi;
      fix_hi   = is_div ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
      fix_lo   = is_div ? q_fix : prod_fix[WIDTH-1:0];
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         cnt             <= '0;
         p_hi            <= '0;
         p_lo            <= '0;
         mcand           <= '0;
         neg_q           <= 1'b0;
         neg_r           <= 1'b0;
         is_div          <= 1'b0;
         dbz_pend        <= 1'b0;
         bus.ready       <= 1'b1;
         bus.done        <= 1'b0;
         bus.hi          <= '0;
         bus.lo          <= '0;
         bus.zero        <= 1'b1;
         bus.div_by_zero <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (is_mul_op) begin
                     state     <= MUL;
                     bus.ready <= 1'b0;
                     cnt       <= SHW'(WIDTH-1);
                     p_hi      <= '0;
                     p_lo      <= mag_b;
                     mcand     <= mag_a;
                     neg_q     <= sgn_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                     neg_r     <= 1'b0;
                     is_div    <= 1'b0;
                     dbz_pend  <= 1'b0;
                  end else if (is_div_op) begin
                     state     <= DIV;
                     bus.ready <= 1'b0;
                     cnt       <= SHW'(WIDTH-1);
                     p_hi      <= '0;
                     p_lo      <= mag_a;
                     mcand     <= mag_b;
                     neg_q     <= sgn_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                     neg_r     <= sgn_op & bus.a[WIDTH-1];
                     is_div    <= 1'b1;
                     dbz_pend  <= (bus.b == '0);
                  end else begin
                     bus.lo          <= alu_res;
                     bus.hi          <= '0;
                     bus.zero        <= (alu_res == '0);
                     bus.div_by_zero <= 1'b0;
                     bus.done        <= 1'b1;
                  end
               end
            end
            MUL: begin
               p_hi <= mul_sum[WIDTH:1];
               p_lo <= {mul_sum[0], p_lo[WIDTH-1:1]};
               if (cnt == '0) state <= FIX;
               else           cnt   <= cnt - SHW'(1);
            end
            DIV: begin
               p_hi <= div_r_nx;
               p_lo <= div_q_nx;
               if (cnt == '0) state <= FIX;
               else           cnt   <= cnt - SHW'(1);
            end
            FIX: begin
               bus.hi          <= fix_hi;
               bus.lo          <= fix_lo;
               bus.zero        <= (fix_lo == '0);
               bus.div_by_zero <= is_div & dbz_pend;
               bus.done        <= 1'b1;
               bus.ready       <= 1'b1;
               state           <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu at WIDTH=32 and WIDTH=8.
// Latency: checks done timing cycle-by-cycle after each accept.
// Backpressure: pokes start mid-operation and checks it is ignored.
module tb_alu_mdu;

   logic clk;
   logic rst32;
   logic rst8;

   alu_mdu_if #(.WIDTH(32)) b32 ();
   alu_mdu_if #(.WIDTH(8))  b8  ();

   alu_mdu #(.WIDTH(32)) u32 (.clk(clk), .reset(rst32), .bus(b32));
   alu_mdu #(.WIDTH(8))  u8  (.clk(clk), .reset(rst8),  .bus(b8));

   int tests = 0;
   int fails = 0;
   int fd;
   int nd;
   bit bok;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one request on the 32-bit unit and watch ncyc cycles after accept.
   task automatic run32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input int poke, input int ncyc,
                        output int first_done, output int ndone, output bit busy_ok);
      b32.start = 1'b1; b32.op = op; b32.a = a; b32.b = b; b32.shamt = sh;
      @(posedge clk); #1;
      b32.start = 1'b0; b32.op = 5'b00100; b32.a = 32'hDEADBEEF; b32.b = 32'h0BADF00D;
      first_done = 0; ndone = 0; busy_ok = 1'b1;
      for (int c = 1; c <= ncyc; c++) begin
         if (b32.done) begin
            ndone++;
            if (first_done == 0) first_done = c;
         end else if (first_done == 0 && b32.ready) begin
            busy_ok = 1'b0;
         end
         if (c == poke) begin
            b32.start = 1'b1; b32.op = 5'b00100; b32.a = 32'd1; b32.b = 32'd1;
         end
         @(posedge clk); #1;
         b32.start = 1'b0;
      end
   endtask

   task automatic run8(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] sh, input int ncyc,
                       output int first_done, output int ndone, output bit busy_ok);
      b8.start = 1'b1; b8.op = op; b8.a = a; b8.b = b; b8.shamt = sh;
      @(posedge clk); #1;
      b8.start = 1'b0; b8.op = 5'b00100; b8.a = 8'h5A; b8.b = 8'hA5;
      first_done = 0; ndone = 0; busy_ok = 1'b1;
      for (int c = 1; c <= ncyc; c++) begin
         if (b8.done) begin
            ndone++;
            if (first_done == 0) first_done = c;
         end else if (first_done == 0 && b8.ready) begin
            busy_ok = 1'b0;
         end
         @(posedge clk); #1;
      end
   endtask

   // Linear directed sequence.
   initial begin
      rst32 = 1'b1; rst8 = 1'b1;
      b32.start = 1'b0; b32.op = '0; b32.a = '0; b32.b = '0; b32.shamt = '0;
      b8.start  = 1'b0; b8.op  = '0; b8.a  = '0; b8.b  = '0; b8.shamt  = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst32_flags", {b32.ready, b32.done, b32.zero, b32.div_by_zero}, 4'b1010);
      chk("rst32_hilo",  {b32.hi, b32.lo}, 64'h0);
      chk("rst8_state",  {b8.ready, b8.done, b8.zero, b8.div_by_zero, b8.hi, b8.lo}, {4'b1010, 16'h0});
      rst32 = 1'b0; rst8 = 1'b0;

      // ---------------- WIDTH=32 ----------------
      run32(5'b00100, 32'h7FFFFFFF, 32'h1, 5'd0, 0, 4, fd, nd, bok);
      chk("add_lat", fd, 1);
      chk("add_ndone", nd, 1);
      chk("add_res", {b32.hi, b32.lo, b32.zero}, {32'h0, 32'h80000000, 1'b0});
      run32(5'b00101, 32'd5, 32'd5, 5'd0, 0, 2, fd, nd, bok);
      chk("sub_res", {b32.lo, b32.zero}, {32'h0, 1'b1});
      run32(5'b01100, 32'h80000000, 32'h1, 5'd0, 0, 2, fd, nd, bok);
      chk("slt_min", b32.lo, 32'h1);
      run32(5'b01101, 32'h80000000, 32'h1, 5'd0, 0, 2, fd, nd, bok);
      chk("sltu_big", b32.lo, 32'h0);
      run32(5'b01101, 32'd2, 32'd3, 5'd0, 0, 2, fd, nd, bok);
      chk("sltu_lt", b32.lo, 32'h1);
      run32(5'b01101, 32'd3, 32'd3, 5'd0, 0, 2, fd, nd, bok);
      chk("sltu_eq", b32.lo, 32'h0);
      run32(5'b01010, 32'h0, 32'hF0000000, 5'd4, 0, 2, fd, nd, bok);
      chk("sra", b32.lo, 32'hFF000000);
      run32(5'b01001, 32'h0, 32'hF0000000, 5'd4, 0, 2, fd, nd, bok);
      chk("srl", b32.lo, 32'h0F000000);
      run32(5'b01000, 32'h0, 32'h1, 5'd31, 0, 2, fd, nd, bok);
      chk("sll", b32.lo, 32'h80000000);
      run32(5'b00000, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 0, 2, fd, nd, bok);
      chk("and", b32.lo, 32'hF000F000);
      run32(5'b00001, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 0, 2, fd, nd, bok);
      chk("or", b32.lo, 32'hFFF0FFF0);
      run32(5'b00010, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 0, 2, fd, nd, bok);
      chk("nor", b32.lo, 32'h000F000F);
      run32(5'b00011, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 0, 2, fd, nd, bok);
      chk("xor", b32.lo, 32'h0FF00FF0);

      run32(5'b00110, 32'hFFFFFFFF, 32'd2, 5'd0, 0, 40, fd, nd, bok);
      chk("mult_lat", fd, 34);
      chk("mult_busy", bok, 1'b1);
      chk("mult_ndone", nd, 1);
      chk("mult_res", {b32.hi, b32.lo}, 64'hFFFFFFFF_FFFFFFFE);
      chk("mult_rdy", b32.ready, 1'b1);
      run32(5'b00111, 32'hFFFFFFFF, 32'd2, 5'd0, 0, 36, fd, nd, bok);
      chk("multu_res", {b32.hi, b32.lo}, 64'h00000001_FFFFFFFE);
      run32(5'b11111, 32'h12345678, 32'h9ABCDEF0, 5'd3, 0, 2, fd, nd, bok);
      chk("undef_op", {b32.hi, b32.lo, b32.zero, 6'(fd)}, {64'h0, 1'b1, 6'd1});
      run32(5'b00110, 32'hFFFFFFFD, 32'd5, 5'd0, 0, 36, fd, nd, bok);
      chk("mult_neg3x5", {b32.hi, b32.lo}, 64'hFFFFFFFF_FFFFFFF1);
      run32(5'b00111, 32'h00010000, 32'h00010000, 5'd0, 0, 36, fd, nd, bok);
      chk("multu_2p32", {b32.hi, b32.lo, b32.zero}, {64'h00000001_00000000, 1'b1});

      run32(5'b10000, 32'hFFFFFFF9, 32'd2, 5'd0, 0, 36, fd, nd, bok);
      chk("div_lat", fd, 34);
      chk("div_m7_2", {b32.lo, b32.hi, b32.div_by_zero}, {32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0});
      run32(5'b10000, 32'd7, 32'hFFFFFFFE, 5'd0, 0, 36, fd, nd, bok);
      chk("div_7_m2", {b32.lo, b32.hi}, {32'hFFFFFFFD, 32'h1});
      run32(5'b10001, 32'd7, 32'd0, 5'd0, 0, 36, fd, nd, bok);
      chk("divu_by0", {b32.lo, b32.hi, b32.div_by_zero, 6'(fd)}, {32'hFFFFFFFF, 32'd7, 1'b1, 6'd34});
      run32(5'b00100, 32'd1, 32'd1, 5'd0, 0, 2, fd, nd, bok);
      chk("add_clr_dbz", {b32.lo, b32.div_by_zero}, {32'd2, 1'b0});
      run32(5'b10000, 32'hFFFFFFF8, 32'd0, 5'd0, 0, 36, fd, nd, bok);
      chk("div_neg_by0", {b32.lo, b32.hi, b32.div_by_zero}, {32'hFFFFFFFF, 32'hFFFFFFF8, 1'b1});
      run32(5'b10000, 32'h80000000, 32'hFFFFFFFF, 5'd0, 5, 40, fd, nd, bok);
      chk("div_ovf_res", {b32.lo, b32.hi, b32.div_by_zero}, {32'h80000000, 32'h0, 1'b0});
      chk("div_ovf_ndone", nd, 1);
      chk("div_ovf_lat", fd, 34);
      run32(5'b10001, 32'd100, 32'd7, 5'd0, 0, 36, fd, nd, bok);
      chk("divu_100_7", {b32.lo, b32.hi}, {32'd14, 32'd2});

      // Reset during cycle 10 of a mult.
      b32.start = 1'b1; b32.op = 5'b00110; b32.a = 32'd3; b32.b = 32'd3;
      @(posedge clk); #1;
      b32.start = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      rst32 = 1'b1;
      @(posedge clk); #1;
      rst32 = 1'b0;
      chk("rst_mid_state", {b32.ready, b32.done, b32.hi, b32.lo}, {2'b10, 64'h0});
      nd = 0;
      for (int c = 0; c < 40; c++) begin
         if (b32.done) nd++;
         @(posedge clk); #1;
      end
      chk("rst_mid_nodone", nd, 0);

      // ---------------- WIDTH=8 ----------------
      run8(5'b00100, 8'h7F, 8'h01, 3'd0, 2, fd, nd, bok);
      chk("w8_add", {b8.lo, b8.hi, b8.zero, 6'(fd)}, {8'h80, 8'h00, 1'b0, 6'd1});
      run8(5'b00110, 8'hFF, 8'h02, 3'd0, 14, fd, nd, bok);
      chk("w8_mult_lat", fd, 10);
      chk("w8_mult_busy", {bok, 6'(nd)}, {1'b1, 6'd1});
      chk("w8_mult_res", {b8.hi, b8.lo}, 16'hFFFE);
      run8(5'b00111, 8'hFF, 8'h02, 3'd0, 12, fd, nd, bok);
      chk("w8_multu_res", {b8.hi, b8.lo}, 16'h01FE);
      run8(5'b10000, 8'hF9, 8'h02, 3'd0, 12, fd, nd, bok);
      chk("w8_div_m7_2", {b8.lo, b8.hi, 6'(fd)}, {16'hFDFF, 6'd10});
      run8(5'b10001, 8'h07, 8'h00, 3'd0, 12, fd, nd, bok);
      chk("w8_divu_by0", {b8.lo, b8.hi, b8.div_by_zero}, {16'hFF07, 1'b1});
      run8(5'b10000, 8'h80, 8'hFF, 3'd0, 12, fd, nd, bok);
      chk("w8_div_ovf", {b8.lo, b8.hi, b8.div_by_zero}, {16'h8000, 1'b0});
      run8(5'b01100, 8'h80, 8'h01, 3'd0, 2, fd, nd, bok);
      chk("w8_slt", b8.lo, 8'h01);
      run8(5'b01011, 8'h00, 8'hF0, 3'd4, 2, fd, nd, bok);
      chk("w8_sra", b8.lo, 8'hFF);

      b8.start = 1'b1; b8.op = 5'b00111; b8.a = 8'h03; b8.b = 8'h03;
      @(posedge clk); #1;
      b8.start = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      rst8 = 1'b1;
      @(posedge clk); #1;
      rst8 = 1'b0;
      chk("w8_rst_mid", {b8.ready, b8.done, b8.hi, b8.lo}, {2'b10, 16'h0});
      nd = 0;
      for (int c = 0; c < 14; c++) begin
         if (b8.done) nd++;
         @(posedge clk); #1;
      end
      chk("w8_rst_nodone", nd, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
Parametrised, sequential successor to the combinational datapath ALU. It registers results into HI/LO and adds an iterative multiply/divide unit (shift-add multiply, restoring divide). Single-cycle ops complete in 1 cycle; mult/div are multi-cycle behind a start/ready/done handshake. It sits in the execute stage and stalls the pipeline via ready.

Parameters:
WIDTH, 32, operand/result width; power of two, >= 8
SHW, $clog2(WIDTH), shift-amount width (derived; do not override)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; accepted only in a cycle where ready=1
op  input  5  operation select (encoding below)
a  input  WIDTH  operand A, sampled on the accepting edge
b  input  WIDTH  operand B, sampled on the accepting edge
shamt  input  SHW  shift amount, sampled on the accepting edge
ready  output  1  1 = idle, can accept start
done  output  1  one-cycle pulse: hi/lo/zero/div_by_zero updated this cycle
hi  output  WIDTH  high result / remainder (registered)
lo  output  WIDTH  low result / quotient (registered)
zero  output  1  registered (lo == 0), updated with lo
div_by_zero  output  1  registered; set on a div/divu with b==0, cleared on any other completion

Behaviour:
- Reset (synchronous, active-high): ready=1, done=0, hi=0, lo=0, zero=1, div_by_zero=0, FSM=IDLE. Reset mid-operation aborts: no done pulse, partial results discarded.
- Op encoding: 00000 and, 00001 or, 00010 nor, 00011 xor, 00100 add, 00101 sub, 00110 mult (signed), 00111 multu, 01000 sll b<<shamt, 01001 srl b>>shamt, 0101x sra b>>>shamt, 01100 slt, 01101 sltu, 10000 div (signed), 10001 divu. Any other code completes as a single-cycle op with hi=lo=0.
- Single-cycle ops: start in cycle 0 -> done=1 in cycle 1; lo=result, hi=0. add/sub wrap modulo 2^WIDTH with no overflow flag.
- slt: lo=1 iff a<b as two's complement, correct at the sign-differing extremes (no overflow error). sltu: lo=1 iff a<b unsigned; lo=0 when a==b.
- FSM states: IDLE, MUL, DIV, FIX. IDLE + start + mult/multu -> MUL; + div/divu -> DIV. MUL/DIV run exactly WIDTH iterations (internal counter WIDTH-1..0), then FIX (sign correction and result write), then IDLE. ready=0 in MUL/DIV/FIX.
- Multi-cycle latency: start in cycle 0 -> done=1 in cycle WIDTH+2 (34 for WIDTH=32). ready returns to 1 in the same cycle as done, so back-to-back start is allowed on the done cycle.
- mult/multu: {hi,lo} = full 2*WIDTH-bit product. Signed multiply uses magnitude iteration plus a negate in FIX.
- div/divu: lo=quotient, hi=remainder. Signed quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero (b==0): lo=all ones, hi=a, div_by_zero=1. Normal latency still applies.
- Signed overflow (a=MIN, b=-1): lo=MIN, hi=0.
- start while ready=0 is ignored; it is neither queued nor able to corrupt the in-flight op. Operand changes after the accepting edge have no effect.
- hi, lo, zero, and div_by_zero hold their values between done pulses.

Test Plan:
- Reset then add a=0x7FFFFFFF, b=1 -> cycle 1: done=1, lo=0x80000000, hi=0, zero=0; then sub a=5, b=5 -> lo=0, zero=1.
- slt a=0x80000000, b=1 -> lo=1. sltu with the same operands -> lo=0. sltu a=3, b=3 -> lo=0. sra b=0xF0000000, shamt=4 -> lo=0xFF000000.
- mult a=0xFFFFFFFF (-1), b=2 -> done exactly in cycle 34, {hi,lo}=0xFFFFFFFF_FFFFFFFE. multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE. ready=0 in cycles 1..33.
- div a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu a=7, b=0 -> lo=0xFFFFFFFF, hi=7, div_by_zero=1. A following add clears div_by_zero.
- div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. A start pulsed mid-divide with op=add is ignored, and only one done pulse occurs.
- Assert reset in cycle 10 of a mult -> next cycle: ready=1, hi=lo=0, no done pulse. Repeat the Test Plan items with WIDTH=8: mult latency is 10 cycles.
